// File: rtl/ram_ctrl_initiator.sv
// Host-side valid/ready front end that sequences address/readWrite/enable/data strobes for a small flop RAM.
// Build with RAM_CTRL_INIT_EN defined to zero-fill every RAM word after each reset before accepting requests.
module ram_ctrl_initiator #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] LAT_C = 2'(RD_LAT);

`ifdef RAM_CTRL_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD_WAIT, S_RESP, S_INIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_WAIT, S_RESP} state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_en_q, mem_en_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge clk) begin
    if (clear) begin
`ifdef RAM_CTRL_INIT_EN
      state_q  <= S_INIT;
      mem_en_q <= 1'b1;
      mem_rw_q <= 1'b1;
`else
      state_q  <= S_IDLE;
      mem_en_q <= 1'b0;
      mem_rw_q <= 1'b0;
`endif
      cnt_q       <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_en_q    <= mem_en_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_rw_d    = mem_rw_q;
    mem_en_d    = mem_en_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_addr_d  = req_addr;
          mem_rw_d    = req_rw;
          mem_wdata_d = req_wdata;
          mem_en_d    = 1'b1;
          if (req_rw) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RD_WAIT;
            cnt_d   = LAT_C;
          end
        end
      end
      S_WRITE: begin
        mem_en_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_RD_WAIT: begin
        // Strobe is held for RD_LAT cycles; the word is valid one cycle after it drops.
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) mem_en_d = 1'b0;
        end else begin
          rsp_rdata_d = mem_rdata;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
`ifdef RAM_CTRL_INIT_EN
      S_INIT: begin
        if (mem_addr_q == LAST_ADDR) begin
          mem_en_d = 1'b0;
          mem_rw_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rw    = mem_rw_q;
  assign mem_en    = mem_en_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_ctrl_initiator.sv
// Bench for ram_ctrl_initiator: two instances (RD_LAT 1 and 3) each driving a behavioural flop RAM,
// with read results and latencies predicted from a word-array reference and latency arithmetic.
module tb_ram_ctrl_initiator;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;

  logic          req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr, mem_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, mem_wdata, mem_rdata;
  logic          mem_rw, mem_en, busy;

  logic          req_valid3, req_ready3, req_rw3, rsp_valid3, rsp_ready3;
  logic [AW-1:0] req_addr3, mem_addr3;
  logic [DW-1:0] req_wdata3, rsp_rdata3, mem_wdata3, mem_rdata3;
  logic          mem_rw3, mem_en3, busy3;

  ram_ctrl_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT1)) u_dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_en(mem_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  ram_ctrl_initiator #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT3)) u_dut3 (
    .clk(clk), .clear(clear),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_rw(req_rw3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .mem_addr(mem_addr3), .mem_rw(mem_rw3), .mem_en(mem_en3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Flop RAMs: read data appears LAT cycles after a strobe cycle, junk otherwise.
  logic [DW-1:0] ram1 [4] = '{default: '0};
  logic [DW-1:0] ram3 [4] = '{default: '0};
  logic [DW-1:0] rd1_q;
  logic [DW-1:0] p3 [3];
  int wr_strobes = 0;
  int rd_strobes = 0;

  always @(posedge clk) begin
    if (mem_en && mem_rw) ram1[mem_addr] <= mem_wdata;
    rd1_q <= (mem_en && !mem_rw) ? ram1[mem_addr] : DW'($urandom);
    if (mem_en && mem_rw) wr_strobes <= wr_strobes + 1;
    if (mem_en && !mem_rw) rd_strobes <= rd_strobes + 1;
  end
  assign mem_rdata = rd1_q;

  always @(posedge clk) begin
    if (mem_en3 && mem_rw3) ram3[mem_addr3] <= mem_wdata3;
    p3[0] <= (mem_en3 && !mem_rw3) ? ram3[mem_addr3] : DW'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rdata3 = p3[2];

  logic [DW-1:0] ref1 [4] = '{default: '0};
  int exp_wr = 0;
  int exp_rd = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready1();
    int t = 0;
    while (!req_ready && t < 20) begin
      step();
      t++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic finish_read1(input logic [AW-1:0] a, input int hold);
    int lat = 0;
    while (!rsp_valid && lat < 12) begin
      step();
      lat++;
    end
    check("rd_latency", 32'(lat), 32'(LAT1 + 1));
    check("rd_data", 32'(rsp_rdata), 32'(ref1[a]));
    for (int i = 0; i < hold; i++) begin
      step();
      check("rsp_hold", 32'({rsp_valid, rsp_rdata, req_ready}), 32'({1'b1, ref1[a], 1'b0}));
    end
    rsp_ready = 1'b1;
    step();
    check("rsp_consumed", 32'({rsp_valid, busy}), 32'd0);
  endtask

  task automatic do_write1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready1();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_addr = AW'($urandom); req_wdata = DW'($urandom);
    check("wr_strobe", 32'({mem_en, mem_rw, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, a, d}));
    check("wr_busy", 32'({busy, req_ready}), 32'b10);
    ref1[a] = d;
    exp_wr++;
    step();
    check("wr_done", 32'({mem_en, busy}), 32'd0);
  endtask

  task automatic do_read1(input logic [AW-1:0] a, input int hold);
    wait_ready1();
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_wdata = DW'($urandom);
    step();
    req_valid = 1'b0; req_addr = AW'($urandom);
    check("rd_strobe", 32'({mem_en, mem_rw, mem_addr}), 32'({1'b1, 1'b0, a}));
    exp_rd += LAT1;
    finish_read1(a, hold);
  endtask

  initial begin
    clear = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 2'd2; req_wdata = 4'hF;
    req_valid3 = 1'b0; req_rw3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b1;
    step();
    step();
`ifdef RAM_CTRL_INIT_EN
    check("reset_init_busy", 32'({busy, req_ready, rsp_valid}), 32'b100);
    clear = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("init_write", 32'({mem_en, mem_rw, mem_addr, mem_wdata, req_ready}),
            32'({1'b1, 1'b1, 2'(i), 4'd0, 1'b0}));
      step();
    end
    check("init_done", 32'({req_ready, busy, mem_en}), 32'b100);
`else
    check("reset_outputs",
          32'({req_ready, rsp_valid, rsp_rdata, mem_addr, mem_rw, mem_en, mem_wdata, busy}),
          32'({1'b1, 1'b0, 4'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0}));
    clear = 1'b0; req_valid = 1'b0;
    step();
    check("reset_idle", 32'({busy, mem_en, req_ready}), 32'b001);
`endif

    // Write then read at addr 2, then backpressured read at the top address.
    do_write1(2'd2, 4'b1001);
    do_read1(2'd2, 0);
    do_write1(2'd3, 4'b0011);
    do_read1(2'd3, 5);

    // Back-to-back with req_valid held high; req_* changes right after each accept.
    wait_ready1();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 2'd0; req_wdata = 4'b1011;
    step();
    req_addr = 2'd1; req_wdata = 4'b0110;
    check("b2b_w0", 32'({mem_en, mem_rw, mem_addr, mem_wdata, req_ready}), 32'({1'b1, 1'b1, 2'd0, 4'b1011, 1'b0}));
    step();
    check("b2b_gap0", 32'({mem_en, req_ready}), 32'b01);
    step();
    req_rw = 1'b0; req_addr = 2'd0;
    check("b2b_w1", 32'({mem_en, mem_rw, mem_addr, mem_wdata, req_ready}), 32'({1'b1, 1'b1, 2'd1, 4'b0110, 1'b0}));
    step();
    check("b2b_gap1", 32'({mem_en, req_ready}), 32'b01);
    step();
    req_valid = 1'b0;
    check("b2b_r0", 32'({mem_en, mem_rw, mem_addr, req_ready}), 32'({1'b1, 1'b0, 2'd0, 1'b0}));
    ref1[0] = 4'b1011; ref1[1] = 4'b0110;
    exp_wr += 2; exp_rd += LAT1;
    finish_read1(2'd0, 0);

    // Reset in the middle of a read drops it entirely.
    wait_ready1();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 2'd1;
    step();
    req_valid = 1'b0;
    check("mr_strobe", 32'(mem_en), 32'd1);
    exp_rd += 1;
    clear = 1'b1;
    step();
    clear = 1'b0;
`ifdef RAM_CTRL_INIT_EN
    repeat (4) step();
`else
    check("mr_reset", 32'({busy, rsp_valid, mem_en, req_ready}), 32'b0001);
`endif
    begin
      int seen = 0;
      repeat (6) begin
        step();
        if (rsp_valid) seen++;
      end
      check("mr_no_stale", 32'(seen), 32'd0);
    end

    // Randomized traffic against the word-array reference.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) do_write1(AW'($urandom), DW'($urandom));
      else do_read1(AW'($urandom), int'($urandom_range(0, 2)));
    end

    // RD_LAT = 3 instance.
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int lat;
      int en_cyc;
      a = AW'($urandom);
      d = DW'($urandom);
      req_valid3 = 1'b1; req_rw3 = 1'b1; req_addr3 = a; req_wdata3 = d;
      step();
      req_valid3 = 1'b0;
      step();
      req_valid3 = 1'b1; req_rw3 = 1'b0; req_addr3 = a;
      step();
      req_valid3 = 1'b0; req_addr3 = AW'($urandom);
      lat = 0; en_cyc = 0;
      while (!rsp_valid3 && lat < 12) begin
        if (mem_en3) en_cyc++;
        step();
        lat++;
      end
      check("lat3_latency", 32'(lat), 32'(LAT3 + 1));
      check("lat3_en_cycles", 32'(en_cyc), 32'(LAT3));
      check("lat3_data", 32'(rsp_rdata3), 32'(d));
      step();
      check("lat3_consumed", 32'({rsp_valid3, busy3}), 32'd0);
    end

`ifndef RAM_CTRL_INIT_EN
    check("write_strobe_cycles", 32'(wr_strobes), 32'(exp_wr));
    check("read_strobe_cycles", 32'(rd_strobes), 32'(exp_rd));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
